// File: rtl/wb_pipe_reg_if.sv
// MEM/WB pipeline register bus: stall/flush controls, writeback entry in/out, forwarding lookup.
// Latency: n/a (wiring only).
// Backpressure: none on the bus itself; i_en=0 stalls the whole pipe.
interface wb_pipe_reg_if #(
  parameter int DATA_W = 32,
  parameter int DIR_W  = 4
);
  logic              i_en;
  logic              i_flush;
  logic              i_we;
  logic [DATA_W-1:0] i_wb_data;
  logic [DIR_W-1:0]  i_wb_dir;
  logic              o_we;
  logic [DATA_W-1:0] o_wb_data;
  logic [DIR_W-1:0]  o_wb_dir;
  logic              o_busy;
  logic [DIR_W-1:0]  i_fwd_dir;
  logic              o_fwd_hit;
  logic [DATA_W-1:0] o_fwd_data;

  // Pipeline side: consumes controls and MEM entry, produces writeback and lookup results.
  modport slave (
    input  i_en, i_flush, i_we, i_wb_data, i_wb_dir, i_fwd_dir,
    output o_we, o_wb_data, o_wb_dir, o_busy, o_fwd_hit, o_fwd_data
  );

  // Driver side: MEM stage / hazard unit / register file view.
  modport master (
    output i_en, i_flush, i_we, i_wb_data, i_wb_dir, i_fwd_dir,
    input  o_we, o_wb_data, o_wb_dir, o_busy, o_fwd_hit, o_fwd_data
  );
endinterface

// File: rtl/wb_pipe_reg.sv
// MEM/WB pipeline register, DEPTH stages (1..8), with stall, flush and optional forwarding lookup.
// Latency: DEPTH enabled edges from capture to writeback outputs; lookup is combinational.
// Backpressure: i_en=0 freezes every stage and drops the input; upstream must stall with it.
// Optional feature: define WB_PIPE_FWD_EN to build the forwarding comparator/priority mux.
module wb_pipe_reg #(
  parameter int DATA_W = 32,
  parameter int DIR_W  = 4,
  parameter int DEPTH  = 1
) (
  input logic           clk,
  input logic           rst,
  wb_pipe_reg_if.slave  io_wb
);

  typedef struct packed {
    logic              we;
    logic [DATA_W-1:0] data;
    logic [DIR_W-1:0]  dir;
  } stage_t;

  // r_stage[0] is the youngest entry, r_stage[DEPTH-1] feeds the register file.
  stage_t r_stage [DEPTH];
  stage_t w_in;
  logic   w_busy;

  // Data and dir are captured even for we=0; consumers qualify on we.
  assign w_in = {io_wb.i_we, io_wb.i_wb_data, io_wb.i_wb_dir};

  // Stage shift register: reset and flush clear everything, stall holds everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) r_stage[k] <= '0;
    end else if (io_wb.i_flush) begin
      for (int k = 0; k < DEPTH; k++) r_stage[k] <= '0;
    end else if (io_wb.i_en) begin
      r_stage[0] <= w_in;
      for (int k = 1; k < DEPTH; k++) r_stage[k] <= r_stage[k-1];
    end
  end

  // Busy whenever any in-flight entry still has a pending write.
  always_comb begin
    w_busy = 1'b0;
    for (int k = 0; k < DEPTH; k++) w_busy = w_busy | r_stage[k].we;
  end

  assign io_wb.o_we      = r_stage[DEPTH-1].we;
  assign io_wb.o_wb_data = r_stage[DEPTH-1].data;
  assign io_wb.o_wb_dir  = r_stage[DEPTH-1].dir;
  assign io_wb.o_busy    = w_busy;

`ifdef WB_PIPE_FWD_EN
  logic              w_fwd_hit;
  logic [DATA_W-1:0] w_fwd_data;

  // Scan oldest to youngest so the youngest matching write overrides older ones.
  always_comb begin
    w_fwd_hit  = 1'b0;
    w_fwd_data = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (r_stage[k].we && (r_stage[k].dir == io_wb.i_fwd_dir)) begin
        w_fwd_hit  = 1'b1;
        w_fwd_data = r_stage[k].data;
      end
    end
  end

  assign io_wb.o_fwd_hit  = w_fwd_hit;
  assign io_wb.o_fwd_data = w_fwd_data;
`else
  // Lookup not built: ports stay for a uniform footprint, results are constant zero.
  assign io_wb.o_fwd_hit  = 1'b0;
  assign io_wb.o_fwd_data = '0;
`endif

endmodule

// File: tb/tb_wb_pipe_reg.sv
// Directed bench for wb_pipe_reg: reset, latency (DEPTH=3), stall (DEPTH=2), flush (DEPTH=4), forwarding.
// Latency: checks sampled 1 time unit after each rising edge, or mid-cycle for async reset.
// Backpressure: exercised through i_en stalls on the DEPTH=2 instance.
module tb_wb_pipe_reg;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

`ifdef WB_PIPE_FWD_EN
  localparam bit FWD_ON = 1'b1;
`else
  localparam bit FWD_ON = 1'b0;
`endif

  wb_pipe_reg_if #(.DATA_W(32), .DIR_W(4)) bus3 ();
  wb_pipe_reg_if #(.DATA_W(32), .DIR_W(4)) bus2 ();
  wb_pipe_reg_if #(.DATA_W(32), .DIR_W(4)) bus4 ();

  wb_pipe_reg #(.DATA_W(32), .DIR_W(4), .DEPTH(3)) u_d3 (.clk(clk), .rst(rst), .io_wb(bus3));
  wb_pipe_reg #(.DATA_W(32), .DIR_W(4), .DEPTH(2)) u_d2 (.clk(clk), .rst(rst), .io_wb(bus2));
  wb_pipe_reg #(.DATA_W(32), .DIR_W(4), .DEPTH(4)) u_d4 (.clk(clk), .rst(rst), .io_wb(bus4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running, want done");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive3(input logic en, input logic we, input logic [31:0] d, input logic [3:0] r);
    bus3.i_en = en; bus3.i_we = we; bus3.i_wb_data = d; bus3.i_wb_dir = r;
  endtask

  task automatic drive2(input logic en, input logic we, input logic [31:0] d, input logic [3:0] r);
    bus2.i_en = en; bus2.i_we = we; bus2.i_wb_data = d; bus2.i_wb_dir = r;
  endtask

  task automatic drive4(input logic en, input logic we, input logic [31:0] d, input logic [3:0] r);
    bus4.i_en = en; bus4.i_we = we; bus4.i_wb_data = d; bus4.i_wb_dir = r;
  endtask

  task automatic test_reset();
    logic [37:0] obs;
    // state while reset held from time zero
    obs = {bus3.o_we, bus3.o_wb_data, bus3.o_wb_dir, bus3.o_busy};
    n_vec++;
    if (obs !== 38'h0) begin
      n_err++; $display("FAIL reset_init: got %h want %h", obs, 38'h0);
    end
    rst = 1'b0;
    drive3(1'b1, 1'b1, 32'h1234_5678, 4'd3); tick();
    drive3(1'b1, 1'b1, 32'hCAFE_0001, 4'd4); tick();
    drive3(1'b1, 1'b1, 32'hCAFE_0002, 4'd6); tick();
    // s[2] now holds {1,12345678,3}
    obs = {bus3.o_we, bus3.o_wb_data, bus3.o_wb_dir, bus3.o_busy};
    n_vec++;
    if (obs !== {1'b1, 32'h1234_5678, 4'd3, 1'b1}) begin
      n_err++; $display("FAIL reset_loaded: got %h want %h", obs, {1'b1, 32'h1234_5678, 4'd3, 1'b1});
    end
    // assert reset mid-cycle; outputs must clear before the next edge
    #2 rst = 1'b1;
    #1;
    obs = {bus3.o_we, bus3.o_wb_data, bus3.o_wb_dir, bus3.o_busy};
    n_vec++;
    if (obs !== 38'h0) begin
      n_err++; $display("FAIL reset_async: got %h want %h", obs, 38'h0);
    end
    drive3(1'b1, 1'b0, 32'h0, 4'd0);
    tick();
    rst = 1'b0;
  endtask

  task automatic test_latency();
    logic [36:0] obs;
    logic [36:0] exp_v [4];
    exp_v[0] = 37'h0;
    exp_v[1] = 37'h0;
    exp_v[2] = {1'b1, 32'hDEAD_BEEF, 4'd5};
    exp_v[3] = {1'b0, 32'h0, 4'd0};
    drive3(1'b1, 1'b1, 32'hDEAD_BEEF, 4'd5);
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 0) drive3(1'b1, 1'b0, 32'h0, 4'd0);
      obs = {bus3.o_we, bus3.o_wb_data, bus3.o_wb_dir};
      n_vec++;
      if (obs !== exp_v[i]) begin
        n_err++; $display("FAIL latency_edge%0d: got %h want %h", i + 1, obs, exp_v[i]);
      end
    end
  endtask

  task automatic test_stall();
    logic [37:0] obs;
    drive2(1'b1, 1'b1, 32'h11, 4'd2); tick();
    drive2(1'b1, 1'b1, 32'h22, 4'd3); tick();
    // stalled input must be dropped
    drive2(1'b0, 1'b1, 32'h33, 4'd4);
    for (int i = 0; i < 4; i++) begin
      tick();
      obs = {bus2.o_we, bus2.o_wb_data, bus2.o_wb_dir, bus2.o_busy};
      n_vec++;
      if (obs !== {1'b1, 32'h11, 4'd2, 1'b1}) begin
        n_err++; $display("FAIL stall_hold%0d: got %h want %h", i, obs, {1'b1, 32'h11, 4'd2, 1'b1});
      end
    end
    drive2(1'b1, 1'b0, 32'h0, 4'd0);
    tick();
    obs = {bus2.o_we, bus2.o_wb_data, bus2.o_wb_dir, bus2.o_busy};
    n_vec++;
    if (obs !== {1'b1, 32'h22, 4'd3, 1'b1}) begin
      n_err++; $display("FAIL stall_resume: got %h want %h", obs, {1'b1, 32'h22, 4'd3, 1'b1});
    end
    tick();
    obs = {bus2.o_we, bus2.o_wb_data, bus2.o_wb_dir, bus2.o_busy};
    n_vec++;
    if (obs !== 38'h0) begin
      n_err++; $display("FAIL stall_drain: got %h want %h", obs, 38'h0);
    end
  endtask

  task automatic test_flush();
    logic [37:0] obs;
    drive4(1'b1, 1'b1, 32'h1, 4'd1); tick();
    drive4(1'b1, 1'b1, 32'h2, 4'd2); tick();
    drive4(1'b1, 1'b1, 32'h3, 4'd3); tick();
    n_vec++;
    if (bus4.o_busy !== 1'b1 || bus4.o_we !== 1'b0) begin
      n_err++; $display("FAIL flush_preload: got busy=%b we=%b want busy=1 we=0", bus4.o_busy, bus4.o_we);
    end
    bus4.i_flush = 1'b1;
    drive4(1'b0, 1'b1, 32'h99, 4'd9);
    tick();
    bus4.i_flush = 1'b0;
    obs = {bus4.o_we, bus4.o_wb_data, bus4.o_wb_dir, bus4.o_busy};
    n_vec++;
    if (obs !== 38'h0) begin
      n_err++; $display("FAIL flush_clear: got %h want %h", obs, 38'h0);
    end
    // first capture after flush emerges after exactly DEPTH enabled edges
    drive4(1'b1, 1'b1, 32'h55, 4'd6);
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 0) drive4(1'b1, 1'b0, 32'h0, 4'd0);
      obs = {bus4.o_we, bus4.o_wb_data, bus4.o_wb_dir, bus4.o_busy};
      n_vec++;
      if (i < 3) begin
        if (obs !== {1'b0, 32'h0, 4'd0, 1'b1}) begin
          n_err++; $display("FAIL flush_refill%0d: got %h want %h", i + 1, obs, {1'b0, 32'h0, 4'd0, 1'b1});
        end
      end else begin
        if (obs !== {1'b1, 32'h55, 4'd6, 1'b1}) begin
          n_err++; $display("FAIL flush_refill%0d: got %h want %h", i + 1, obs, {1'b1, 32'h55, 4'd6, 1'b1});
        end
      end
    end
  endtask

  task automatic test_forwarding();
    logic [32:0] obs;
    logic [32:0] exp_hit_aaaa;
    logic [36:0] pobs;
    exp_hit_aaaa = FWD_ON ? {1'b1, 32'hAAAA} : 33'h0;
    drive3(1'b1, 1'b1, 32'hBBBB, 4'd7); tick();
    drive3(1'b1, 1'b0, 32'hCCCC, 4'd7); tick();
    drive3(1'b1, 1'b1, 32'hAAAA, 4'd7); tick();
    drive3(1'b0, 1'b0, 32'h0, 4'd0);
    // s0={1,AAAA,7} s1={0,CCCC,7} s2={1,BBBB,7}
    bus3.i_fwd_dir = 4'd7; #1;
    obs = {bus3.o_fwd_hit, bus3.o_fwd_data};
    n_vec++;
    if (obs !== exp_hit_aaaa) begin
      n_err++; $display("FAIL fwd_youngest: got %h want %h", obs, exp_hit_aaaa);
    end
    pobs = {bus3.o_we, bus3.o_wb_data, bus3.o_wb_dir};
    n_vec++;
    if (pobs !== {1'b1, 32'hBBBB, 4'd7}) begin
      n_err++; $display("FAIL fwd_pipe_out: got %h want %h", pobs, {1'b1, 32'hBBBB, 4'd7});
    end
    bus3.i_fwd_dir = 4'd9; #1;
    obs = {bus3.o_fwd_hit, bus3.o_fwd_data};
    n_vec++;
    if (obs !== 33'h0) begin
      n_err++; $display("FAIL fwd_miss: got %h want %h", obs, 33'h0);
    end
    // youngest stages get we=0 entries to dir 7; the older AAAA write must still win
    bus3.i_fwd_dir = 4'd7;
    drive3(1'b1, 1'b0, 32'hDDDD, 4'd7); tick();
    obs = {bus3.o_fwd_hit, bus3.o_fwd_data};
    n_vec++;
    if (obs !== exp_hit_aaaa) begin
      n_err++; $display("FAIL fwd_skip_s0: got %h want %h", obs, exp_hit_aaaa);
    end
    drive3(1'b1, 1'b0, 32'hEEEE, 4'd7); tick();
    obs = {bus3.o_fwd_hit, bus3.o_fwd_data};
    n_vec++;
    if (obs !== exp_hit_aaaa) begin
      n_err++; $display("FAIL fwd_oldest: got %h want %h", obs, exp_hit_aaaa);
    end
    pobs = {bus3.o_we, bus3.o_wb_data, bus3.o_wb_dir};
    n_vec++;
    if (pobs !== {1'b1, 32'hAAAA, 4'd7}) begin
      n_err++; $display("FAIL fwd_pipe_out2: got %h want %h", pobs, {1'b1, 32'hAAAA, 4'd7});
    end
    drive3(1'b1, 1'b0, 32'h0, 4'd0); tick();
    obs = {bus3.o_fwd_hit, bus3.o_fwd_data};
    n_vec++;
    if (obs !== 33'h0 || bus3.o_busy !== 1'b0) begin
      n_err++; $display("FAIL fwd_none_valid: got %h busy=%b want %h busy=0", obs, bus3.o_busy, 33'h0);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    bus3.i_flush = 1'b0; bus2.i_flush = 1'b0; bus4.i_flush = 1'b0;
    bus3.i_fwd_dir = 4'd0; bus2.i_fwd_dir = 4'd0; bus4.i_fwd_dir = 4'd0;
    drive3(1'b0, 1'b0, 32'h0, 4'd0);
    drive2(1'b0, 1'b0, 32'h0, 4'd0);
    drive4(1'b0, 1'b0, 32'h0, 4'd0);
    tick();
    tick();
    test_reset();
    test_latency();
    test_stall();
    test_flush();
    test_forwarding();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
